// File: rtl/response_receiver_if.sv
// Handshake/result bundle between the SPI command engine and response_receiver.
// Signal prefixes follow the receiver's point of view (i_ into it, o_ out of it).
interface response_receiver_if;
  logic        i_start;
  logic [5:0]  i_cmd_select;
  logic        i_byte_valid;
  logic [7:0]  i_rx_byte;
  logic        o_busy;
  logic        o_resp_done;
  logic        o_resp_timeout;
  logic [7:0]  o_r1;
  logic [31:0] o_ocr_data;
  logic        o_r1_error;
  logic        o_echo_error;

  modport master (
    output i_start, i_cmd_select, i_byte_valid, i_rx_byte,
    input  o_busy, o_resp_done, o_resp_timeout, o_r1, o_ocr_data,
           o_r1_error, o_echo_error
  );

  modport slave (
    input  i_start, i_cmd_select, i_byte_valid, i_rx_byte,
    output o_busy, o_resp_done, o_resp_timeout, o_r1, o_ocr_data,
           o_r1_error, o_echo_error
  );
endinterface

// File: rtl/response_receiver.sv
// Captures an SD-card SPI command response (R1, R3 or R7) after a command is sent.
// Define R7_ECHO_CHECK_EN to compare the CMD8 voltage/check-pattern echo.
module response_receiver #(
  parameter int NCR_MAX = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  response_receiver_if.slave bus
);

  localparam int CW = (NCR_MAX < 2) ? 1 : $clog2(NCR_MAX);
  localparam logic [CW-1:0] FILL_LAST = CW'(NCR_MAX - 1);
  localparam logic [5:0]    CMD_R7    = 6'd8;
  localparam logic [5:0]    CMD_R3    = 6'd58;

  typedef enum logic [1:0] {IDLE, WAIT_R1, DATA, DONE} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_fillCount;
  logic [1:0]    r_byteIdx;
  logic [5:0]    r_cmdSel;
  logic [7:0]    r_r1;
  logic [31:0]   r_ocr;
  logic          r_r1Error;
  logic          r_respTimeout;

  logic          w_accept;
  logic          w_fillInc;
  logic          w_timeout;
  logic          w_captureR1;
  logic          w_shiftData;
  logic          w_longResp;
  logic          w_lastData;
  logic [31:0]   w_ocrNext;

  assign w_longResp = (r_cmdSel == CMD_R7) || (r_cmdSel == CMD_R3);
  assign w_ocrNext  = {r_ocr[23:0], bus.i_rx_byte};
  assign w_lastData = w_shiftData && (r_byteIdx == 2'd3);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Bytes with bit7 set before R1 are Ncr filler; only byte_valid advances anything.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_fillInc   = 1'b0;
    w_timeout   = 1'b0;
    w_captureR1 = 1'b0;
    w_shiftData = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_accept    = 1'b1;
          w_nextState = WAIT_R1;
        end
      end
      WAIT_R1: begin
        if (bus.i_byte_valid) begin
          if (bus.i_rx_byte[7]) begin
            if (r_fillCount == FILL_LAST) begin
              w_timeout   = 1'b1;
              w_nextState = IDLE;
            end else begin
              w_fillInc = 1'b1;
            end
          end else begin
            w_captureR1 = 1'b1;
            w_nextState = w_longResp ? DATA : DONE;
          end
        end
      end
      DATA: begin
        if (bus.i_byte_valid) begin
          w_shiftData = 1'b1;
          if (r_byteIdx == 2'd3) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_fillCount   <= '0;
      r_byteIdx     <= 2'd0;
      r_cmdSel      <= 6'd0;
      r_r1          <= 8'hFF;
      r_ocr         <= 32'd0;
      r_r1Error     <= 1'b0;
      r_respTimeout <= 1'b0;
    end else begin
      r_respTimeout <= w_timeout;
      if (w_accept) begin
        r_fillCount <= '0;
        r_byteIdx   <= 2'd0;
        r_cmdSel    <= bus.i_cmd_select;
        r_r1        <= 8'h00;
        r_ocr       <= 32'd0;
        r_r1Error   <= 1'b0;
      end
      if (w_fillInc) begin
        r_fillCount <= r_fillCount + CW'(1);
      end
      if (w_captureR1) begin
        r_r1      <= bus.i_rx_byte;
        r_r1Error <= |bus.i_rx_byte[6:1];
        r_byteIdx <= 2'd0;
      end
      if (w_shiftData) begin
        r_ocr     <= w_ocrNext;
        r_byteIdx <= r_byteIdx + 2'd1;
      end
    end
  end

`ifdef R7_ECHO_CHECK_EN
  logic r_echoError;
  logic w_echoOk;

  // Evaluated on the incoming final byte so the flag is valid alongside resp_done.
  assign w_echoOk = (w_ocrNext[11:8] == 4'h1) && (w_ocrNext[7:0] == 8'hAA);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_echoError <= 1'b0;
    end else if (w_accept) begin
      r_echoError <= 1'b0;
    end else if (w_lastData && (r_cmdSel == CMD_R7)) begin
      r_echoError <= !w_echoOk;
    end
  end

  assign bus.o_echo_error = r_echoError;
`else
  assign bus.o_echo_error = 1'b0;
`endif

  assign bus.o_busy         = (r_state != IDLE);
  assign bus.o_resp_done    = (r_state == DONE);
  assign bus.o_resp_timeout = r_respTimeout;
  assign bus.o_r1           = r_r1;
  assign bus.o_ocr_data     = r_ocr;
  assign bus.o_r1_error     = r_r1Error;

endmodule

// File: tb/tb_response_receiver.sv
// Directed self-checking bench for response_receiver; expected values are hand-computed.
// Echo expectations follow R7_ECHO_CHECK_EN when it is defined for the build.
module tb_response_receiver;

  logic clk;
  logic n_rst;
  int   vectors;
  int   miscompares;
  logic expEcho;

  response_receiver_if bus ();

  response_receiver #(.NCR_MAX(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [5:0] cmd,
                               input logic bv, input logic [7:0] b);
    bus.i_start      = st;
    bus.i_cmd_select = cmd;
    bus.i_byte_valid = bv;
    bus.i_rx_byte    = b;
    tick();
    bus.i_start      = 1'b0;
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 6'd0, 1'b1, b);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    n_rst            = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_cmd_select = 6'd0;
    bus.i_byte_valid = 1'b0;
    bus.i_rx_byte    = 8'h00;
`ifdef R7_ECHO_CHECK_EN
    expEcho = 1'b1;
`else
    expEcho = 1'b0;
`endif

    tick();
    tick();
    checkOutput("rst_busy", bus.o_busy, 0);
    checkOutput("rst_done", bus.o_resp_done, 0);
    checkOutput("rst_timeout", bus.o_resp_timeout, 0);
    checkOutput("rst_r1", bus.o_r1, 32'hFF);
    checkOutput("rst_ocr", bus.o_ocr_data, 0);
    checkOutput("rst_r1err", bus.o_r1_error, 0);
    checkOutput("rst_echo", bus.o_echo_error, 0);
    n_rst = 1'b1;
    tick();

    // R1 with fillers; the byte coincident with start must be dropped
    applyStimulus(1'b1, 6'd0, 1'b1, 8'h00);
    checkOutput("r1_busy_start", bus.o_busy, 1);
    checkOutput("r1_no_early_done", bus.o_resp_done, 0);
    sendByte(8'hFF);
    sendByte(8'hFF);
    tick();
    tick();
    tick();
    checkOutput("r1_idle_busy", bus.o_busy, 1);
    checkOutput("r1_idle_done", bus.o_resp_done, 0);
    sendByte(8'h01);
    checkOutput("r1_done", bus.o_resp_done, 1);
    checkOutput("r1_value", bus.o_r1, 32'h01);
    checkOutput("r1_err", bus.o_r1_error, 0);
    tick();
    checkOutput("r1_done_pulse", bus.o_resp_done, 0);
    checkOutput("r1_busy_after", bus.o_busy, 0);
    checkOutput("r1_hold", bus.o_r1, 32'h01);

    // R7 with correct echo
    applyStimulus(1'b1, 6'd8, 1'b0, 8'h00);
    sendByte(8'hFF);
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h01);
    checkOutput("r7_not_done_yet", bus.o_resp_done, 0);
    sendByte(8'hAA);
    checkOutput("r7_done", bus.o_resp_done, 1);
    checkOutput("r7_r1", bus.o_r1, 32'h01);
    checkOutput("r7_ocr", bus.o_ocr_data, 32'h000001AA);
    checkOutput("r7_echo_ok", bus.o_echo_error, 0);
    tick();

    // R7 with wrong check pattern
    applyStimulus(1'b1, 6'd8, 1'b0, 8'h00);
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'h55);
    checkOutput("r7b_done", bus.o_resp_done, 1);
    checkOutput("r7b_ocr", bus.o_ocr_data, 32'h00000155);
    checkOutput("r7b_echo", bus.o_echo_error, {31'd0, expEcho});
    tick();
    checkOutput("r7b_echo_hold", bus.o_echo_error, {31'd0, expEcho});

    // Timeout after eight fillers
    applyStimulus(1'b1, 6'd17, 1'b0, 8'h00);
    checkOutput("to_echo_cleared", bus.o_echo_error, 0);
    for (int i = 0; i < 7; i++) sendByte(8'hFF);
    checkOutput("to_busy_7", bus.o_busy, 1);
    checkOutput("to_no_timeout_7", bus.o_resp_timeout, 0);
    sendByte(8'hFF);
    checkOutput("to_timeout", bus.o_resp_timeout, 1);
    checkOutput("to_no_done", bus.o_resp_done, 0);
    checkOutput("to_idle", bus.o_busy, 0);
    tick();
    checkOutput("to_pulse", bus.o_resp_timeout, 0);

    // R3 with an ignored start during DATA
    applyStimulus(1'b1, 6'd58, 1'b0, 8'h00);
    sendByte(8'h00);
    sendByte(8'hC0);
    applyStimulus(1'b1, 6'd0, 1'b0, 8'h00);
    checkOutput("r3_busy_midstart", bus.o_busy, 1);
    sendByte(8'hFF);
    sendByte(8'h80);
    checkOutput("r3_not_done_yet", bus.o_resp_done, 0);
    sendByte(8'h00);
    checkOutput("r3_done", bus.o_resp_done, 1);
    checkOutput("r3_r1", bus.o_r1, 32'h00);
    checkOutput("r3_ocr", bus.o_ocr_data, 32'hC0FF8000);
    checkOutput("r3_echo", bus.o_echo_error, 0);
    tick();

    // Reset mid-DATA abandons the capture
    applyStimulus(1'b1, 6'd58, 1'b0, 8'h00);
    sendByte(8'h01);
    sendByte(8'h12);
    sendByte(8'h34);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    checkOutput("mr_busy", bus.o_busy, 0);
    checkOutput("mr_done", bus.o_resp_done, 0);
    checkOutput("mr_timeout", bus.o_resp_timeout, 0);
    checkOutput("mr_r1", bus.o_r1, 32'hFF);
    checkOutput("mr_ocr", bus.o_ocr_data, 0);
    sendByte(8'h56);
    sendByte(8'h78);
    checkOutput("mr_no_done", bus.o_resp_done, 0);
    checkOutput("mr_still_idle", bus.o_busy, 0);
    checkOutput("mr_ocr_frozen", bus.o_ocr_data, 0);

    // Error bit in R1
    applyStimulus(1'b1, 6'd24, 1'b0, 8'h00);
    sendByte(8'h04);
    checkOutput("err_done", bus.o_resp_done, 1);
    checkOutput("err_r1", bus.o_r1, 32'h04);
    checkOutput("err_flag", bus.o_r1_error, 1);
    tick();
    checkOutput("err_flag_hold", bus.o_r1_error, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/response_receiver.md
RESPONSE_RECEIVER -- requirements
Module: response_receiver

Interface
REQ-001 Parameter NCR_MAX, default 8: maximum number of 0xFF filler bytes accepted before the response start byte.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse issued after the last command byte has been transmitted.
REQ-005 cmd_select  input  6  index of the command just sent; latched on an accepted start.
REQ-006 byte_valid  input  1  one-cycle pulse marking that rx_byte holds a newly shifted MISO byte.
REQ-007 rx_byte  input  8  byte received from the SPI shifter.
REQ-008 busy  output  1  high from an accepted start until resp_done or resp_timeout.
REQ-009 resp_done  output  1  one-cycle pulse indicating that the complete response has been captured.
REQ-010 resp_timeout  output  1  one-cycle pulse indicating that no start byte arrived within NCR_MAX bytes.
REQ-011 r1  output  8  captured R1 byte.
REQ-012 ocr_data  output  32  trailing 32 bits of an R3 or R7 response, first received byte in [31:24].
REQ-013 r1_error  output  1  high when any of r1[6:1] is set; bit0 (idle) is not an error.
REQ-014 echo_error  output  1  CMD8 echo-mismatch flag (see Configuration).

Function
REQ-015 States: IDLE, WAIT_R1, DATA, DONE.
REQ-016 Response type by latched cmd_select: 8 -> R7 (5 bytes); 58 -> R3 (5 bytes); any other value, including 0/17/24/63 -> R1 (1 byte).
REQ-017 IDLE: start=1 -> WAIT_R1, filler counter cleared, cmd_select latched, r1/ocr_data/r1_error/echo_error cleared; byte_valid ignored.
REQ-018 Same cycle start and byte_valid in IDLE: start accepted, byte discarded.
REQ-019 start while not IDLE: ignored, no state change.
REQ-020 WAIT_R1, byte_valid with rx_byte[7]=1: filler counter +1; when the counter reaches NCR_MAX, resp_timeout pulses and state -> IDLE.
REQ-021 WAIT_R1, byte_valid with rx_byte[7]=0: r1 <= rx_byte; R1 type -> DONE; R3/R7 type -> DATA with byte index 0.
REQ-022 DATA: each byte_valid shifts rx_byte into ocr_data from the MSB down; the 4th byte -> DONE.
REQ-023 DONE: resp_done=1 for exactly one cycle, then -> IDLE; latency is one cycle after the edge capturing the final byte.
REQ-024 r1, ocr_data, r1_error and echo_error hold their values until the next accepted start.
REQ-025 Cycles without byte_valid never advance counters; there is no cycle-based timeout.
REQ-026 busy = (state != IDLE), combinational from the state register.

Reset
REQ-027 n_rst=0 at a clock edge: state IDLE, counters 0, busy/resp_done/resp_timeout 0, r1=8'hFF, ocr_data=0, r1_error=0, echo_error=0.
REQ-028 Reset mid-response abandons the capture with no done or timeout pulse.

Configuration
REQ-029 Macro R7_ECHO_CHECK_EN defined: on resp_done for cmd_select=8, echo_error=1 unless ocr_data[11:8]==4'h1 and ocr_data[7:0]==8'hAA.
REQ-030 Macro R7_ECHO_CHECK_EN undefined: echo_error is tied to 0 and no comparison logic is generated.

Verification
REQ-031 start, cmd_select=0; bytes FF, FF, 01 -> resp_done one cycle after the 01 byte, r1=01, r1_error=0, busy low afterwards.
REQ-032 start, cmd_select=8; bytes FF, 01, 00, 00, 01, AA -> resp_done, r1=01, ocr_data=32'h000001AA, echo_error=0; with 01, 00, 00, 01, 55 -> echo_error=1 when the macro is defined and 0 when it is not.
REQ-033 start, cmd_select=17; eight FF bytes -> resp_timeout pulse on the 8th byte, no resp_done, state IDLE.
REQ-034 start, cmd_select=58; bytes 00, C0, FF, 80, 00 -> r1=00, ocr_data=32'hC0FF8000; a second start pulse during DATA is ignored.
REQ-035 n_rst low after 2 of 4 DATA bytes -> all outputs at reset values, no pulses; a subsequent cmd_select=24 response 04 -> r1_error=1.
